hw_px_source: RTL and testbench

//  Frame-buffer reader and pixel-stream transmitter. It drives the unfiltered row-major pixel stream into hw_dut's px_in port.
//  On start it reads (W+1)*(H+1) pixels from a synchronous-read frame RAM at linear addresses 0..N-1.
//  It presents them on a ready/valid stream with last_x/last_y framing and sustains 1 px/clk when the sink is always ready.

---
 rtl/hw_px_source.sv | 234 +++++++++++++++++++++++
 tb/tb_hw_px_source.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hw_px_source.sv
// hw_px_source
//   Frame-buffer reader and pixel-stream transmitter. On an accepted start it
//   reads (cfg_width+1)*(cfg_height+1) pixels from a synchronous-read frame
//   RAM at linear addresses 0..N-1 and streams them out in row-major order
//   with last_x/last_y framing. Sustains one pixel per clock while the sink
//   stays ready.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   cfg_width       image width minus one, latched on accepted start
//   cfg_height      image height minus one, latched on accepted start
//   start           begin a frame; only honoured when idle or done
//   mem_rd_en       frame RAM read strobe
//   mem_rd_addr     frame RAM read address
//   mem_rd_data     RAM data, valid exactly one clock after mem_rd_en
//   px_out_ready    sink ready
//   px_out_valid    pixel valid
//   px_out_last_x   last pixel of each row
//   px_out_last_y   every pixel of the last row
//   px_out_data     pixel data
//   busy            frame in progress (RUN or DRAIN)
//   done            level; set when the last pixel is accepted, cleared by
//                   the next accepted start
//
// Handshake: a pixel transfers on a rising clk edge where px_out_valid and
// px_out_ready are both high. Once px_out_valid is raised it stays high, with
// data and framing bits stable, until that transfer happens.

module hw_px_source #(
    parameter int XB = 10,
    parameter int YB = 10,
    parameter int PB = 8,
    parameter int AB = XB + YB
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [XB-1:0] cfg_width,
    input  logic [YB-1:0] cfg_height,
    input  logic          start,
    output logic          mem_rd_en,
    output logic [AB-1:0] mem_rd_addr,
    input  logic [PB-1:0] mem_rd_data,
    input  logic          px_out_ready,
    output logic          px_out_valid,
    output logic          px_out_last_x,
    output logic          px_out_last_y,
    output logic [PB-1:0] px_out_data,
    output logic          busy,
    output logic          done
);

    localparam int EW = PB + 2;  // {last_x, last_y, data}

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_n;

    // Frame geometry and read-side counters
    logic [XB-1:0] w_q;
    logic [YB-1:0] h_q;
    logic [XB-1:0] rd_x;
    logic [YB-1:0] rd_y;
    logic [AB-1:0] rd_addr;

    // Read in flight: its framing bits travel alongside it
    logic inflight, inf_lx, inf_ly;

    // Output register
    logic          out_valid, out_lx, out_ly;
    logic [PB-1:0] out_data;

    // Two-entry skid FIFO, entry 0 is the head
    logic [EW-1:0] skid0, skid1, skid0_n, skid1_n;
    logic [1:0]    skid_cnt, skid_cnt_n;

    logic done_q;

    logic          start_acc, issue, issue_lx, issue_ly;
    logic          pop, last_acc, out_free, take_skid, land_direct, push;
    logic [2:0]    occupancy;
    logic [EW-1:0] land_word;

    assign start_acc = start && (state == S_IDLE || state == S_DONE);

    // Reads in flight plus skid entries bounds what can still arrive with
    // nowhere to go; capping it at one before issuing keeps the skid from
    // overflowing whatever the sink does.
    assign occupancy = {2'b00, inflight} + {1'b0, skid_cnt};
    assign issue     = (state == S_RUN) && (occupancy <= 3'd1);
    assign issue_lx  = (rd_x == w_q);
    assign issue_ly  = (rd_y == h_q);

    assign pop       = out_valid && px_out_ready;
    assign last_acc  = pop && out_lx && out_ly;
    assign out_free  = pop || !out_valid;
    assign land_word = {inf_lx, inf_ly, mem_rd_data};

    // Returning data bypasses the skid only when the skid is empty, which
    // keeps pixels in FIFO order.
    assign take_skid   = out_free && (skid_cnt != 2'd0);
    assign land_direct = inflight && (skid_cnt == 2'd0) && out_free;
    assign push        = inflight && !land_direct;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start_acc) state_n = S_RUN;
            S_RUN:   if (issue && issue_lx && issue_ly) state_n = S_DRAIN;
            S_DRAIN: if (last_acc) state_n = S_DONE;
            S_DONE:  if (start_acc) state_n = S_RUN;
            default: state_n = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ read side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q      <= '0;
            h_q      <= '0;
            rd_x     <= '0;
            rd_y     <= '0;
            rd_addr  <= '0;
            inflight <= 1'b0;
            inf_lx   <= 1'b0;
            inf_ly   <= 1'b0;
        end else begin
            if (start_acc) begin
                w_q     <= cfg_width;
                h_q     <= cfg_height;
                rd_x    <= '0;
                rd_y    <= '0;
                rd_addr <= '0;
            end else if (issue) begin
                rd_addr <= rd_addr + 1'b1;
                if (issue_lx) begin
                    rd_x <= '0;
                    rd_y <= rd_y + 1'b1;
                end else begin
                    rd_x <= rd_x + 1'b1;
                end
            end
            inflight <= issue;
            if (issue) begin
                inf_lx <= issue_lx;
                inf_ly <= issue_ly;
            end
        end
    end

    // ------------------------------------------------------ skid FIFO
    always_comb begin
        skid0_n    = skid0;
        skid1_n    = skid1;
        skid_cnt_n = skid_cnt;
        if (take_skid) begin
            skid0_n    = skid1;
            skid_cnt_n = skid_cnt - 2'd1;
        end
        if (push) begin
            if (skid_cnt_n == 2'd0) begin
                skid0_n = land_word;
            end else begin
                skid1_n = land_word;
            end
            skid_cnt_n = skid_cnt_n + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid0    <= '0;
            skid1    <= '0;
            skid_cnt <= 2'd0;
        end else begin
            skid0    <= skid0_n;
            skid1    <= skid1_n;
            skid_cnt <= skid_cnt_n;
        end
    end

    // ------------------------------------------------ output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_lx    <= 1'b0;
            out_ly    <= 1'b0;
            out_data  <= '0;
        end else if (out_free) begin
            if (skid_cnt != 2'd0) begin
                out_valid                  <= 1'b1;
                {out_lx, out_ly, out_data} <= skid0;
            end else if (inflight) begin
                out_valid                  <= 1'b1;
                {out_lx, out_ly, out_data} <= land_word;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else if (start_acc) begin
            done_q <= 1'b0;
        end else if (last_acc) begin
            done_q <= 1'b1;
        end
    end

    assign mem_rd_en     = issue;
    assign mem_rd_addr   = rd_addr;
    assign px_out_valid  = out_valid;
    assign px_out_last_x = out_lx;
    assign px_out_last_y = out_ly;
    assign px_out_data   = out_data;
    assign busy          = (state == S_RUN) || (state == S_DRAIN);
    assign done          = done_q;

endmodule

// File: tb/tb_hw_px_source.sv
module tb_hw_px_source;

  localparam int XB = 10;
  localparam int YB = 10;
  localparam int PB = 8;
  localparam int AB = XB + YB;
  localparam int W  = PB + 2;  // {last_x, last_y, data}

  logic          clk;
  logic          rst_n;
  logic [XB-1:0] cfg_width;
  logic [YB-1:0] cfg_height;
  logic          start;
  logic          mem_rd_en;
  logic [AB-1:0] mem_rd_addr;
  logic [PB-1:0] mem_rd_data;
  logic          px_out_ready;
  logic          px_out_valid;
  logic          px_out_last_x;
  logic          px_out_last_y;
  logic [PB-1:0] px_out_data;
  logic          busy;
  logic          done;

  hw_px_source #(.XB(XB), .YB(YB), .PB(PB), .AB(AB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .start        (start),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .px_out_ready (px_out_ready),
    .px_out_valid (px_out_valid),
    .px_out_last_x(px_out_last_x),
    .px_out_last_y(px_out_last_y),
    .px_out_data  (px_out_data),
    .busy         (busy),
    .done         (done)
  );

  // ---------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_fail   = 0;
  int rd_issued = 0;
  int accepted  = 0;
  int frame_len = 0;
  int cyc = 0;
  int first_acc_cyc = 0;
  int last_acc_cyc  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [7:0]   ram_seed = 8'h00;
  int           ready_mode = 0;  // 0: always ready, 1: random, 2: never
  bit           scramble = 0;
  bit           stall_pending = 0;
  logic [W-1:0] stall_word = '0;
  bit           expect_done = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] ram_f(logic [AB-1:0] a);
    return (a[7:0] ^ ram_seed) + a[15:8];
  endfunction

  // ------------------------------------------------------ clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset(string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_valid"}, px_out_valid, 0);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_last_x"}, px_out_last_x, 0);
    check({tag, "_last_y"}, px_out_last_y, 0);
    check({tag, "_data"}, px_out_data, 0);
    exp_q.delete();
    stall_pending = 0;
    expect_done = 0;
    scramble = 0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ----------------------------------------------- frame RAM and sink
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram_f(mem_rd_addr);
  end

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       px_out_ready = 1'b1;
      1:       px_out_ready = 1'($urandom_range(0, 1));
      default: px_out_ready = 1'b0;
    endcase
    if (scramble) begin
      cfg_width  = XB'($urandom_range(0, (1 << XB) - 1));
      cfg_height = YB'($urandom_range(0, (1 << YB) - 1));
    end
  end

  // ------------------------------------------------------------- model
  task automatic load_model(int w, int h);
    exp_q.delete();
    got_q.delete();
    frame_len = (w + 1) * (h + 1);
    for (int n = 0; n < frame_len; n++) begin
      int x = n % (w + 1);
      int y = n / (w + 1);
      exp_q.push_back({x == w, y == h, ram_f(AB'(n))});
    end
  endtask

  // ---------------------------------------------------------- drivers
  task automatic start_frame(int w, int h, logic [7:0] seed);
    scramble = 0;
    ram_seed = seed;
    load_model(w, h);
    rd_issued = 0;
    accepted = 0;
    expect_done = 0;
    @(posedge clk);
    #1;
    cfg_width  = XB'(w);
    cfg_height = YB'(h);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble = 1;
    @(negedge clk);
    check("start_busy", busy, 1);
    check("start_done_clr", done, 0);
    check("start_rd_en", mem_rd_en, 1);
    check("start_addr0", mem_rd_addr, 0);
    check("start_valid_low", px_out_valid, 0);
  endtask

  task automatic wait_done(int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1 && exp_q.size() == 0) ok = 1;
    end
    check("frame_done", ok, 1);
    check("reads_total", rd_issued, frame_len);
    check("beats_total", accepted, frame_len);
  endtask

  // -------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      logic [W-1:0] cur;
      cur = {px_out_last_x, px_out_last_y, px_out_data};
      if (expect_done) begin
        check("done_after_last", done, 1);
        check("busy_after_last", busy, 0);
        check("valid_after_last", px_out_valid, 0);
        expect_done = 0;
      end
      if (stall_pending) begin
        check("stall_valid", px_out_valid, 1);
        check("stall_word", cur, stall_word);
      end
      stall_pending = px_out_valid && !px_out_ready;
      stall_word = cur;
      if (px_out_valid && px_out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h, expected no beat (t=%0t)", cur, $time);
        end else begin
          check("beat", cur, exp_q.pop_front());
          if (exp_q.size() == 0) expect_done = 1;
        end
        got_q.push_back(cur);
        if (accepted == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        accepted++;
      end
      if (mem_rd_en) begin
        check("rd_addr", mem_rd_addr, rd_issued);
        check("rd_en_busy", busy, 1);
        rd_issued++;
      end
      check("outstanding_le3", 32'(rd_issued - accepted <= 3), 1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ------------------------------------------------------------ tests
  initial begin
    bit ok;
    cfg_width = '0;
    cfg_height = '0;
    start = 1'b0;
    px_out_ready = 1'b0;
    mem_rd_data = '0;
    apply_reset("reset");

    // 4x3 frame, always ready: latency pins and back-to-back beats
    ready_mode = 0;
    start_frame(3, 2, 8'h00);
    @(negedge clk);
    check("lat_valid_e1", px_out_valid, 0);
    @(negedge clk);
    check("lat_valid_e2", px_out_valid, 1);
    check("lat_data_e2", px_out_data, 0);
    wait_done(200);
    check("t1_count", got_q.size(), 12);
    check("t1_beat0", got_q[0], {1'b0, 1'b0, 8'd0});
    check("t1_beat3", got_q[3], {1'b1, 1'b0, 8'd3});
    check("t1_beat7", got_q[7], {1'b1, 1'b0, 8'd7});
    check("t1_beat8", got_q[8], {1'b0, 1'b1, 8'd8});
    check("t1_beat11", got_q[11], {1'b1, 1'b1, 8'd11});
    check("t1_no_bubbles", last_acc_cyc - first_acc_cyc, 11);

    // same frame, random backpressure
    ready_mode = 1;
    start_frame(3, 2, 8'h00);
    wait_done(1000);
    check("t2_beat11", got_q[11], {1'b1, 1'b1, 8'd11});

    // single-pixel frame
    ready_mode = 0;
    start_frame(0, 0, 8'hA5);
    wait_done(100);
    check("t3_count", got_q.size(), 1);
    check("t3_beat0", got_q[0], {1'b1, 1'b1, 8'hA5});

    // one-column frame
    start_frame(0, 3, 8'h00);
    wait_done(100);
    check("t4_beat2", got_q[2], {1'b1, 1'b0, 8'd2});
    check("t4_beat3", got_q[3], {1'b1, 1'b1, 8'd3});

    // start during RUN is ignored; start after done replays
    ready_mode = 1;
    start_frame(2, 1, 8'h3C);
    @(posedge clk);
    #1;
    scramble = 0;
    cfg_width = XB'(7);
    cfg_height = YB'(7);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble = 1;
    wait_done(1000);
    start_frame(2, 1, 8'h3C);
    wait_done(1000);

    // random frames under random backpressure
    for (int k = 0; k < 8; k++) begin
      ready_mode = int'($urandom_range(0, 1));
      start_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
                  8'($urandom_range(0, 255)));
      wait_done(2000);
    end

    // reset mid-frame while stalled, then a clean frame
    ready_mode = 0;
    start_frame(3, 2, 8'h00);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (accepted >= 6) ok = 1;
    end
    check("t6_reached_beat5", ok, 1);
    ready_mode = 2;
    @(posedge clk);
    #3;
    check("t6_valid_before_reset", px_out_valid, 1);
    apply_reset("midreset");
    ready_mode = 0;
    start_frame(3, 2, 8'h00);
    wait_done(200);
    check("t6_beat11", got_q[11], {1'b1, 1'b1, 8'd11});

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
